// File: rtl/shift_sequencer.sv
// Sequencer for a single-step registered logical shifter.
// It accepts a word, a shift amount and a direction. It issues one 1-bit
// shift per two cycles to the external shifter, then presents the result.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   in_valid/in_ready     request handshake
//   in_data/in_amt/in_dir word, shift count, direction (1 = right)
//   out_valid/out_ready   result handshake
//   out_data              final shifted word
//   sh_data/sh_dir        registered drive to the shifter
//   sh_result             shifter output, one cycle after sh_data/sh_dir
//   busy                  high whenever the sequencer is not idle
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] sh_data,
    output logic             sh_dir,
    input  logic [WIDTH-1:0] sh_result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] rem_nxt;
    logic [WIDTH-1:0] sh_data_nxt;
    logic             sh_dir_nxt;
    logic [WIDTH-1:0] out_data_nxt;

    logic accept;
    logic amt_zero;
    logic amt_big;
    logic last_step;

    assign accept    = in_valid & in_ready;
    assign amt_zero  = (in_amt == '0);
    // Shifting by WIDTH or more clears the word, so the shifter is bypassed.
    assign amt_big   = (32'(in_amt) >= 32'(WIDTH));
    assign last_step = (rem == CNT_W'(1));

    // State and datapath registers; handshake outputs are decoded from next_state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            work      <= '0;
            rem       <= '0;
            sh_data   <= '0;
            sh_dir    <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            work      <= work_nxt;
            rem       <= rem_nxt;
            sh_data   <= sh_data_nxt;
            sh_dir    <= sh_dir_nxt;
            out_data  <= out_data_nxt;
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
            busy      <= (next_state != IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (amt_zero || amt_big) ? DONE : ISSUE;
                end
            end
            ISSUE:   next_state = CAPTURE;
            CAPTURE: next_state = last_step ? DONE : ISSUE;
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath next values; everything holds unless updated below.
    always_comb begin
        work_nxt     = work;
        rem_nxt      = rem;
        sh_data_nxt  = sh_data;
        sh_dir_nxt   = sh_dir;
        out_data_nxt = out_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    work_nxt   = amt_big ? '0 : in_data;
                    rem_nxt    = in_amt;
                    sh_dir_nxt = in_dir;
                    if (amt_zero || amt_big) begin
                        out_data_nxt = amt_big ? '0 : in_data;
                    end else begin
                        // Load sh_data so it already equals work during ISSUE.
                        sh_data_nxt = in_data;
                    end
                end
            end
            CAPTURE: begin
                work_nxt = sh_result;
                rem_nxt  = rem - CNT_W'(1);
                if (last_step) begin
                    out_data_nxt = sh_result;
                end else begin
                    sh_data_nxt = sh_result;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_amt;
    logic       in_dir;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] sh_data;
    logic       sh_dir;
    logic [7:0] sh_result;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] sh_log [0:63];

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sh_data   (sh_data),
        .sh_dir    (sh_dir),
        .sh_result (sh_result),
        .busy      (busy)
    );

    // Downstream single-step registered logical shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sh_result <= '0;
        else       sh_result <= sh_dir ? (sh_data >> 1) : (sh_data << 1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request at a negedge and consumes the result; returns at a negedge.
    task automatic run(input string tag, input logic [7:0] d, input logic [3:0] amt,
                       input logic dir, input logic [7:0] exp_data, input int exp_cyc,
                       input int hold, input bit tog);
        int n;
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = amt;
        in_dir   = dir;
        @(negedge clk);
        if (!tog) in_valid = 1'b0;
        n = 1;
        sh_log[1] = sh_data;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        while (!out_valid && n < 40) begin
            if (tog) begin
                in_data = 8'($urandom);
                in_dir  = ~in_dir;
                in_amt  = 4'($urandom);
            end
            @(negedge clk);
            n++;
            sh_log[n] = sh_data;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_cyc));
        chk({tag, "_out_data"}, 32'(out_data), 32'(exp_data));
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(out_data), 32'(exp_data));
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_consumed_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_out_data_held"}, 32'(out_data), 32'(exp_data));
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_sh_data", 32'(sh_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run("left1", 8'h81, 4'd1, 1'b0, 8'h02, 3, 0, 1'b0);

        run("right3", 8'hF0, 4'd3, 1'b1, 8'h1E, 7, 0, 1'b0);
        chk("right3_sh1", 32'(sh_log[1]), 32'hF0);
        chk("right3_sh3", 32'(sh_log[3]), 32'h78);
        chk("right3_sh5", 32'(sh_log[5]), 32'h3C);

        run("amt0", 8'hA5, 4'd0, 1'b0, 8'hA5, 1, 0, 1'b0);
        chk("amt0_sh_data", 32'(sh_data), 32'h3C);
        run("amt9", 8'hFF, 4'd9, 1'b0, 8'h00, 1, 0, 1'b0);
        chk("amt9_sh_data", 32'(sh_data), 32'h3C);
        run("left7", 8'h01, 4'd7, 1'b0, 8'h80, 15, 0, 1'b0);

        run("bp", 8'h33, 4'd2, 1'b1, 8'h0C, 5, 5, 1'b0);

        run("stable", 8'h96, 4'd2, 1'b0, 8'h58, 5, 0, 1'b1);

        // Reset during CAPTURE of a 5-step request.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_amt   = 4'd5;
        in_dir   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_sh_dir", 32'(sh_dir), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_sh_data", 32'(sh_data), 32'd0);
        chk("mid_rst_sh_dir", 32'(sh_dir), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_rst_no_valid", 32'(out_valid), 32'd0);
        run("after_rst", 8'h0F, 4'd2, 1'b0, 8'h3C, 5, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Upstream controller for the single-step registered logical shifter. It accepts a word, shift amount and direction, then drives the shifter one step at a time and returns the final result.

Interface
REQ-001 Parameter WIDTH, default 8: data word width; SHALL match the downstream shifter bitwidth.
REQ-002 Parameter CNT_W, default 4: shift-amount width.
REQ-003 clk  input  1  clock; rising edge active.
REQ-004 reset  input  1  reset, asynchronous, active-high; SHALL also be tied to the downstream shifter's reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  sequencer can accept a request.
REQ-007 in_data  input  WIDTH  word to shift.
REQ-008 in_amt  input  CNT_W  number of 1-bit shifts.
REQ-009 in_dir  input  1  1 = right shift, 0 = left shift (logical, zero fill).
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_data  output  WIDTH  shifted result.
REQ-013 sh_data  output  WIDTH  word driven to the shifter dataIn; registered.
REQ-014 sh_dir  output  1  direction driven to the shifter dir; registered.
REQ-015 sh_result  input  WIDTH  shifter dataOut; one-cycle registered latency from sh_data/sh_dir.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, CAPTURE and DONE.
REQ-018 In IDLE, in_ready SHALL be 1; in every other state, in_ready SHALL be 0.
REQ-019 Accept occurs on in_valid & in_ready at a clock edge: work <= in_data, rem <= in_amt, sh_dir <= in_dir.
REQ-020 On accept with in_amt == 0, the next state SHALL be DONE, with the result equal to in_data.
REQ-021 On accept with in_amt >= WIDTH, the next state SHALL be DONE, with the result all zeros and no shifter steps issued.
REQ-022 On accept with 0 < in_amt < WIDTH, the next state SHALL be ISSUE.
REQ-023 ISSUE: sh_data equals work; the next state SHALL be CAPTURE unconditionally.
REQ-024 CAPTURE: work <= sh_result and rem <= rem - 1; the next state SHALL be DONE if rem == 1, otherwise ISSUE.
REQ-025 Each shift step SHALL take exactly 2 cycles; out_valid SHALL rise 2*in_amt+1 cycles after the accept edge (1 cycle for the amt==0 and amt>=WIDTH cases).
REQ-026 DONE: out_valid = 1 and out_data = work, both held stable until out_ready is sampled high.
REQ-027 DONE with out_ready high: the next state SHALL be IDLE, and out_valid SHALL be 0 in the following cycle.
REQ-028 No new request SHALL be accepted in the same cycle that a result is consumed; IDLE is re-entered first.
REQ-029 in_data, in_amt and in_dir SHALL be sampled only at the accept edge; changes during ISSUE, CAPTURE or DONE SHALL have no effect.
REQ-030 out_data SHALL hold its last value outside DONE and SHALL only be qualified by out_valid.
REQ-031 rem SHALL never underflow; CAPTURE is reachable only with rem >= 1.

Reset
REQ-032 Asserting reset at any time, including mid-operation, SHALL force the following, without waiting for a clock edge: state IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, sh_data=0, sh_dir=0, work=0, rem=0.
REQ-033 An operation in flight at reset SHALL be discarded with no out_valid pulse; the first request after reset deasserts SHALL be processed normally.

Verification (WIDTH=8, CNT_W=4, bench includes the downstream shifter)
REQ-034 Left shift: in_data=0x81, amt=1, dir=0 -> out_data=0x02, out_valid at cycle 3 after accept.
REQ-035 Right shift: in_data=0xF0, amt=3, dir=1 -> out_data=0x1E, out_valid at cycle 7; sh_data sequence 0xF0, 0x78, 0x3C.
REQ-036 Boundary amounts: amt=0 with 0xA5 -> 0xA5 at cycle 1; amt=9 with 0xFF -> 0x00 at cycle 1, sh_data unchanged; amt=7 left with 0x01 -> 0x80.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-038 Reset mid-operation: assert reset during CAPTURE of an amt=5 request -> all outputs at reset values immediately, no out_valid; then in_data=0x0F, amt=2, dir=0 -> 0x3C.
REQ-039 Input stability: toggle in_data and in_dir while busy -> result unchanged from the captured request.
